// File: rtl/sdu_mem_bridge.sv
// sdu_mem_bridge
//   UART debug access unit. A host sends binary command frames over an 8N1
//   serial link to read or write one of NCH on-chip memories while the CPU is
//   halted. The unit answers each complete frame over the serial link.
//
//   Frame: CMD (bit7 = write, bits[3:0] = channel, bits[6:4] ignored), then
//   ADDR_W/8 address bytes MSB first, then DATA_W/8 data bytes MSB first
//   (writes only). Responses: write -> 0x06, read -> DATA_W/8 bytes MSB first,
//   channel >= NCH -> 0x15.
//
//   Optional build macro SDU_TIMEOUT_EN: abandons a partial frame after
//   TIMEOUT_BYTES byte times of silence. Without the macro the parser waits
//   indefinitely mid-frame.
//
// Ports
//   clk       system clock
//   rst       synchronous reset, active high
//   rxd       serial input from host (asynchronous)
//   txd       serial output to host
//   mem_addr  shared address to all channels
//   mem_din   shared write data to all channels
//   mem_dout  read data, channel k at [k*DATA_W +: DATA_W]
//   mem_we    one-hot write strobe, one cycle wide
//   busy      high while a frame is executed or answered
//
// Parser states
//   state  | meaning
//   S_CMD  | waiting for the command byte
//   S_ADDR | shifting in address bytes
//   S_DATA | shifting in write data bytes
//   S_MEM  | memory access (strobe or read-latency wait)
//   S_RESP | transmitting the response

module sdu_mem_bridge #(
  parameter int CLK_DIV       = 868,
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int NCH           = 4,
  parameter int RD_LAT        = 1,
  parameter int TIMEOUT_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxd,
  output logic                  txd,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_din,
  input  logic [NCH*DATA_W-1:0] mem_dout,
  output logic [NCH-1:0]        mem_we,
  output logic                  busy
);

  localparam int CW     = $clog2(CLK_DIV);
  localparam int ADDR_B = ADDR_W / 8;
  localparam int DATA_B = DATA_W / 8;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  if (CLK_DIV < 8) begin : g_bad_div
    $error("sdu_mem_bridge: CLK_DIV must be >= 8");
  end
  if ((ADDR_W % 8) != 0 || ADDR_W < 8 || ADDR_W > 32) begin : g_bad_addr
    $error("sdu_mem_bridge: ADDR_W must be a multiple of 8 in 8..32");
  end
  if ((DATA_W % 8) != 0 || DATA_W < 8 || DATA_W > 64) begin : g_bad_data
    $error("sdu_mem_bridge: DATA_W must be a multiple of 8 in 8..64");
  end
  if (NCH < 1 || NCH > 16) begin : g_bad_nch
    $error("sdu_mem_bridge: NCH must be in 1..16");
  end
  if (RD_LAT < 0 || RD_LAT > 3) begin : g_bad_lat
    $error("sdu_mem_bridge: RD_LAT must be in 0..3");
  end
  if (TIMEOUT_BYTES < 1) begin : g_bad_to
    $error("sdu_mem_bridge: TIMEOUT_BYTES must be >= 1");
  end

  // --------------------------------------------------------------------------
  // UART receiver
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t     rx_st_q;
  logic          rx_s1_q, rx_s2_q, rx_s3_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_sh_q;
  logic          rx_vld_q;
  logic          rx_ferr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st_q   <= RX_IDLE;
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_s3_q   <= 1'b1;
      rx_cnt_q  <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
      rx_vld_q  <= 1'b0;
      rx_ferr_q <= 1'b0;
    end else begin
      rx_s1_q   <= rxd;
      rx_s2_q   <= rx_s1_q;
      rx_s3_q   <= rx_s2_q;
      rx_vld_q  <= 1'b0;
      rx_ferr_q <= 1'b0;
      case (rx_st_q)
        RX_IDLE: begin
          if (rx_s3_q && !rx_s2_q) begin
            rx_cnt_q <= CW'(CLK_DIV / 2 - 1);
            rx_st_q  <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt_q != '0) begin
            rx_cnt_q <= rx_cnt_q - CW'(1);
          end else if (rx_s2_q) begin
            rx_st_q <= RX_IDLE;  // glitch, not a start bit
          end else begin
            rx_cnt_q <= CW'(CLK_DIV - 1);
            rx_bit_q <= '0;
            rx_st_q  <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q != '0) begin
            rx_cnt_q <= rx_cnt_q - CW'(1);
          end else begin
            rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
            rx_cnt_q <= CW'(CLK_DIV - 1);
            rx_bit_q <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_st_q <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q != '0) begin
            rx_cnt_q <= rx_cnt_q - CW'(1);
          end else begin
            // Returning to idle mid-stop-bit leaves half a bit of slack for
            // the next start edge.
            rx_vld_q  <= rx_s2_q;
            rx_ferr_q <= !rx_s2_q;
            rx_st_q   <= RX_IDLE;
          end
        end
        default: rx_st_q <= RX_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // UART transmitter
  // --------------------------------------------------------------------------
  logic          tx_act_q;
  logic [8:0]    tx_sh_q;
  logic [3:0]    tx_left_q;
  logic [CW-1:0] tx_cnt_q;
  logic          txd_q;
  logic          tx_req;
  logic [7:0]    tx_byte;
  logic          tx_end;
  logic          tx_load;

  // tx_end is the last cycle of a stop bit; loading there gives back-to-back
  // bytes with no idle gap.
  assign tx_end  = tx_act_q && (tx_cnt_q == '0) && (tx_left_q == 4'd0);
  assign tx_load = tx_req && (!tx_act_q || tx_end);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_act_q  <= 1'b0;
      tx_sh_q   <= '1;
      tx_left_q <= '0;
      tx_cnt_q  <= '0;
      txd_q     <= 1'b1;
    end else if (tx_load) begin
      tx_act_q  <= 1'b1;
      txd_q     <= 1'b0;
      tx_sh_q   <= {1'b1, tx_byte};
      tx_left_q <= 4'd9;
      tx_cnt_q  <= CW'(CLK_DIV - 1);
    end else if (tx_act_q) begin
      if (tx_cnt_q != '0) begin
        tx_cnt_q <= tx_cnt_q - CW'(1);
      end else if (tx_left_q == 4'd0) begin
        tx_act_q <= 1'b0;
      end else begin
        txd_q     <= tx_sh_q[0];
        tx_sh_q   <= {1'b1, tx_sh_q[8:1]};
        tx_left_q <= tx_left_q - 4'd1;
        tx_cnt_q  <= CW'(CLK_DIV - 1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Frame parser / memory access
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {S_CMD, S_ADDR, S_DATA, S_MEM, S_RESP} state_t;

  state_t            state_q;
  logic              is_wr_q;
  logic [3:0]        ch_q;
  logic [2:0]        cnt_q;
  logic [ADDR_W-1:0] addr_sh_q;
  logic [DATA_W-1:0] data_sh_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_din_q;
  logic [NCH-1:0]    mem_we_q;
  logic [1:0]        lat_q;
  logic [DATA_W-1:0] resp_sh_q;
  logic [3:0]        resp_left_q;
  logic              busy_q;

  logic [ADDR_W-1:0] addr_next;
  logic [DATA_W-1:0] data_next;
  logic [DATA_W-1:0] rd_slice;
  logic [NCH-1:0]    we_oh;
  logic              ch_ok;
  logic              frame_done;
  logic              to_hit;

  assign addr_next = (addr_sh_q << 8) | ADDR_W'(rx_sh_q);
  assign data_next = (data_sh_q << 8) | DATA_W'(rx_sh_q);
  assign ch_ok     = (int'(ch_q) < NCH);
  assign tx_req    = (state_q == S_RESP) && (resp_left_q != 4'd0);
  assign tx_byte   = resp_sh_q[DATA_W-1 -: 8];

  // Last byte of a frame arrives: read frames end in S_ADDR, writes in S_DATA.
  assign frame_done = rx_vld_q && (cnt_q == 3'd0) &&
                      ((state_q == S_ADDR && !is_wr_q) || state_q == S_DATA);

  always_comb begin
    rd_slice = '0;
    we_oh    = '0;
    for (int k = 0; k < NCH; k++) begin
      if (int'(ch_q) == k) begin
        rd_slice  = mem_dout[k*DATA_W +: DATA_W];
        we_oh[k]  = 1'b1;
      end
    end
  end

`ifdef SDU_TIMEOUT_EN
  localparam int TO_CYC = TIMEOUT_BYTES * 10 * CLK_DIV;
  localparam int TW     = $clog2(TO_CYC);

  logic [TW-1:0] to_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= TW'(TO_CYC - 1);
    end else if (rx_vld_q) begin
      to_cnt_q <= TW'(TO_CYC - 1);
    end else if (to_cnt_q != '0) begin
      to_cnt_q <= to_cnt_q - TW'(1);
    end
  end

  assign to_hit = (to_cnt_q == '0);
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_CMD;
      is_wr_q     <= 1'b0;
      ch_q        <= '0;
      cnt_q       <= '0;
      addr_sh_q   <= '0;
      data_sh_q   <= '0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      mem_we_q    <= '0;
      lat_q       <= '0;
      resp_sh_q   <= '0;
      resp_left_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      mem_we_q <= '0;
      case (state_q)
        S_CMD: begin
          if (rx_vld_q) begin
            is_wr_q <= rx_sh_q[7];
            ch_q    <= rx_sh_q[3:0];
            cnt_q   <= 3'(ADDR_B - 1);
            state_q <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (rx_ferr_q) begin
            state_q <= S_CMD;
          end else if (rx_vld_q) begin
            addr_sh_q <= addr_next;
            if (cnt_q != 3'd0) begin
              cnt_q <= cnt_q - 3'd1;
            end else if (is_wr_q) begin
              cnt_q   <= 3'(DATA_B - 1);
              state_q <= S_DATA;
            end else begin
              state_q <= S_MEM;
            end
          end else if (to_hit) begin
            state_q <= S_CMD;
          end
        end
        S_DATA: begin
          if (rx_ferr_q) begin
            state_q <= S_CMD;
          end else if (rx_vld_q) begin
            data_sh_q <= data_next;
            if (cnt_q != 3'd0) cnt_q <= cnt_q - 3'd1;
            else               state_q <= S_MEM;
          end else if (to_hit) begin
            state_q <= S_CMD;
          end
        end
        S_MEM: begin
          if (is_wr_q || !ch_ok) begin
            resp_sh_q   <= DATA_W'(ch_ok ? ACK : NAK) << (DATA_W - 8);
            resp_left_q <= 4'd1;
            state_q     <= S_RESP;
          end else if (lat_q == 2'd0) begin
            resp_sh_q   <= rd_slice;
            resp_left_q <= 4'(DATA_B);
            state_q     <= S_RESP;
          end else begin
            lat_q <= lat_q - 2'd1;
          end
        end
        S_RESP: begin
          if (tx_load) begin
            resp_sh_q   <= resp_sh_q << 8;
            resp_left_q <= resp_left_q - 4'd1;
          end else if (tx_end && resp_left_q == 4'd0) begin
            busy_q <= 1'b0;
            // A byte finishing on the exit cycle is taken as the next CMD.
            if (rx_vld_q) begin
              is_wr_q <= rx_sh_q[7];
              ch_q    <= rx_sh_q[3:0];
              cnt_q   <= 3'(ADDR_B - 1);
              state_q <= S_ADDR;
            end else begin
              state_q <= S_CMD;
            end
          end
        end
        default: state_q <= S_CMD;
      endcase

      if (frame_done) begin
        mem_addr_q <= (state_q == S_ADDR) ? addr_next : addr_sh_q;
        if (is_wr_q) mem_din_q <= data_next;
        if (is_wr_q && ch_ok) mem_we_q <= we_oh;
        lat_q  <= 2'(RD_LAT);
        busy_q <= 1'b1;
      end
    end
  end

  assign txd      = txd_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign mem_we   = mem_we_q;
  assign busy     = busy_q;

endmodule
